note_fetch_sequencer: RTL and testbench

- Sequences instruction fetch from the external SRAM for the music player: drives SRAM_A, waits a fixed read latency, captures SRAM_D, and decodes the opcode.
- Note words go into a small prefetch FIFO and are handed to the note executor over a valid/ready handshake.
- BPM words are applied in program order. The END word stops fetching.
- Removes the old scheme where fetch and read were gated off the executor's note counter. The executor now only pops words.

---
 rtl/note_fetch_sequencer.sv | 171 +++++++++++++++++
 tb/tb_note_fetch_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_fetch_sequencer.sv
// Instruction fetch sequencer for the music player: reads program words from
// external SRAM, applies tempo words in order and queues note words for the executor.
module note_fetch_sequencer #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned SRAM_WAIT   = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DEFAULT_BPM = 96
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [15:0]       SRAM_D,
    output logic              ins_valid,
    output logic [15:0]       ins_data,
    input  logic              ins_ready,
    output logic [11:0]       bpm,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [15:0] head;
    logic        head_is_note;
    logic        pop;
    logic        capture;
    logic        word_is_note;
    logic        word_is_bpm;
    logic        word_is_end;
    logic        push;
    logic        fifo_room;
    logic        pc_last;
    logic        issue;
    logic        start_run;
    logic        finish;

    assign head         = fifo_mem[rd_ptr];
    assign head_is_note = (count != '0) && head[15];
    // Tempo words at the head are consumed internally without waiting on the executor.
    assign pop          = (count != '0) && (!head[15] || ins_ready);
    assign capture      = (state == S_WAIT) && (wait_cnt == '0);
    assign word_is_note = SRAM_D[15];
    assign word_is_bpm  = (SRAM_D[15:12] == 4'b0001);
    assign word_is_end  = (SRAM_D[15:12] == 4'b0000);
    assign push         = capture && (word_is_note || word_is_bpm);
    assign fifo_room    = (count < CNT_W'(FIFO_DEPTH));
    assign pc_last      = (pc == {ADDR_W{1'b1}});

    assign ins_valid = head_is_note;
    assign ins_data  = head_is_note ? head : 16'h0000;
    assign busy      = (state != S_IDLE);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        start_run  = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_run  = 1'b1;
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (fifo_room) begin
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (capture) begin
                    // The last address acts as an implicit END so the pc never wraps.
                    state_next = (word_is_end || pc_last) ? S_DRAIN : S_ADDR;
                end
            end
            S_DRAIN: begin
                if (count == '0) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Address, wait counter, prefetch FIFO, tempo and completion flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SRAM_A   <= '0;
            pc       <= '0;
            wait_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            bpm      <= 12'(DEFAULT_BPM);
            done     <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 16'h0000;
            end
        end else begin
            if (issue) begin
                SRAM_A   <= pc;
                wait_cnt <= WAIT_W'(SRAM_WAIT - 1);
            end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end

            if (capture && !pc_last) begin
                pc <= pc + ADDR_W'(1);
            end

            if (start_run) begin
                pc     <= '0;
                bpm    <= 12'(DEFAULT_BPM);
                done   <= 1'b0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fifo_mem[wr_ptr] <= SRAM_D;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    // A zero tempo is ignored so downstream never divides by zero.
                    if (!head[15] && (head[11:0] != 12'h000)) begin
                        bpm <= head[11:0];
                    end
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
                if (finish) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_fetch_sequencer.sv
// Bench for note_fetch_sequencer: directed table, hand sequences and random
// programs scored against a program-order model of notes, tempo and end address.
module tb_note_fetch_sequencer;

    localparam int unsigned ADDR_W = 18;
    localparam int SRAM_N = 64;

    logic              CLK;
    logic              RST;
    logic              start;
    logic [ADDR_W-1:0] SRAM_A;
    logic [15:0]       SRAM_D;
    logic              ins_valid;
    logic [15:0]       ins_data;
    logic              ins_ready;
    logic [11:0]       bpm;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pc;

    logic [15:0] sram [SRAM_N];

    // Small-address instance used to exercise the end-of-address-space stop.
    logic        w_start;
    logic [2:0]  w_sram_a;
    logic [15:0] w_sram_d;
    logic        w_valid;
    logic [15:0] w_data;
    logic        w_ready;
    logic [11:0] w_bpm;
    logic        w_busy;
    logic        w_done;
    logic [2:0]  w_pc;
    logic [15:0] sram_w [8];

    int checks = 0;
    int errors = 0;

    int pops;
    int max_a;
    int first_valid;
    logic [27:0] exp_q [$];

    typedef struct {
        logic [0:9][15:0] prog;
        int               mode;
        int               restart_at;
        int               exp_pc;
        int               exp_notes;
        logic [11:0]      exp_bpm;
    } vec_t;

    vec_t vecs [7];

    note_fetch_sequencer #(
        .ADDR_W(ADDR_W), .SRAM_WAIT(2), .FIFO_DEPTH(4), .DEFAULT_BPM(96)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_ready(ins_ready),
        .bpm(bpm), .busy(busy), .done(done), .pc(pc)
    );

    note_fetch_sequencer #(
        .ADDR_W(3), .SRAM_WAIT(2), .FIFO_DEPTH(4), .DEFAULT_BPM(96)
    ) u_wrap (
        .CLK(CLK), .RST(RST), .start(w_start), .SRAM_A(w_sram_a), .SRAM_D(w_sram_d),
        .ins_valid(w_valid), .ins_data(w_data), .ins_ready(w_ready),
        .bpm(w_bpm), .busy(w_busy), .done(w_done), .pc(w_pc)
    );

    assign SRAM_D   = (SRAM_A < ADDR_W'(SRAM_N)) ? sram[SRAM_A[5:0]] : 16'h0000;
    assign w_sram_d = sram_w[w_sram_a];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return (cyc >= 40);
    endfunction

    task automatic clear_sram();
        for (int i = 0; i < SRAM_N; i++) sram[i] = 16'h0000;
    endtask

    // Start one run of the program in sram and score it against the model.
    task automatic run_prog(input int mode, input int restart_at);
        logic [15:0] w;
        logic [11:0] cur;
        logic [27:0] e;
        int          exp_pc_m;
        logic        prev_v;
        logic        prev_r;
        logic [15:0] prev_d;
        logic        got_done;

        exp_q.delete();
        cur      = 12'd96;
        exp_pc_m = SRAM_N;
        for (int a = 0; a < SRAM_N; a++) begin
            w = sram[a];
            if (w[15]) begin
                exp_q.push_back({cur, w});
            end else if (w[15:12] == 4'h1) begin
                if (w[11:0] != 12'h000) cur = w[11:0];
            end else if (w[15:12] == 4'h0) begin
                exp_pc_m = a + 1;
                break;
            end
        end

        @(negedge CLK);
        start     = 1'b1;
        ins_ready = pick_ready(mode, 0);
        @(negedge CLK);
        start       = 1'b0;
        pops        = 0;
        max_a       = 0;
        first_valid = -1;
        prev_v      = 1'b0;
        prev_r      = 1'b0;
        prev_d      = 16'h0;
        got_done    = 1'b0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            start = (cyc == restart_at);
            if (cyc >= 1 && int'(SRAM_A) > max_a) max_a = int'(SRAM_A);
            if (mode == 2 && cyc == 39) begin
                check("stall_max_sram_a", 32'(max_a), 32'd3);
                check("stall_pc", 32'(pc), 32'd4);
                check("stall_busy", 32'(busy), 32'd1);
            end
            if (ins_valid && first_valid < 0) first_valid = cyc;
            if (prev_v && !prev_r) begin
                check("hold_valid", 32'(ins_valid), 32'd1);
                check("hold_data", 32'(ins_data), 32'(prev_d));
            end
            if (ins_valid) check("valid_is_note", 32'(ins_data[15]), 32'd1);
            ins_ready = pick_ready(mode, cyc + 1);
            if (ins_valid && ins_ready) begin
                check("note_available", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("note_data", 32'(ins_data), 32'(e[15:0]));
                    check("note_bpm", 32'(bpm), 32'(e[27:16]));
                end
                pops++;
            end
            prev_v = ins_valid;
            prev_r = ins_ready;
            prev_d = ins_data;
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0;

        check("done_seen", 32'(got_done), 32'd1);
        check("notes_left", 32'(exp_q.size()), 32'd0);
        check("pc_at_done", 32'(pc), 32'(exp_pc_m));
        check("busy_at_done", 32'(busy), 32'd0);
        check("bpm_at_done", 32'(bpm), 32'(cur));
        check("max_sram_a", 32'(max_a), 32'(exp_pc_m - 1));
        if (sram[0][15]) check("first_valid_latency", 32'(first_valid), 32'd3);
        repeat (3) @(negedge CLK);
        check("done_held", 32'(done), 32'd1);
    endtask

    initial begin
        int idx;
        int n;
        int r;
        int rs;

        vecs[0] = '{{16'h8123, 16'h8245, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    0, -1, 3, 2, 12'd96};
        vecs[1] = '{{16'h8001, 16'h1078, 16'h8002, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    0, -1, 4, 2, 12'd120};
        vecs[2] = '{{16'h1000, 16'h3FFF, 16'h8005, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    0, -1, 4, 1, 12'd96};
        vecs[3] = '{{16'h8001, 16'h8002, 16'h8003, 16'h8004, 16'h8005, 16'h8006, 16'h8007, 16'h8008,
                     16'h0000, 16'h0}, 2, -1, 9, 8, 12'd96};
        vecs[4] = '{{16'h1050, 16'h8000, 16'h1000, 16'h8001, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    1, -1, 5, 2, 12'd80};
        vecs[5] = '{{16'h0000, 16'h8001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    0, -1, 1, 0, 12'd96};
        vecs[6] = '{{16'h8111, 16'h8222, 16'h7ABC, 16'h1C00, 16'h8333, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0},
                    1, 4, 6, 3, 12'hC00};

        for (int i = 0; i < 8; i++) sram_w[i] = 16'h8000 + 16'(i);
        clear_sram();
        RST       = 1'b1;
        start     = 1'b0;
        ins_ready = 1'b0;
        w_start   = 1'b0;
        w_ready   = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        check("rst_sram_a", 32'(SRAM_A), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_bpm", 32'(bpm), 32'd96);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_ins_data", 32'(ins_data), 32'd0);

        // Directed vectors.
        for (int v = 0; v < 7; v++) begin
            clear_sram();
            for (int i = 0; i < 10; i++) sram[i] = vecs[v].prog[i];
            run_prog(vecs[v].mode, vecs[v].restart_at);
            check("tbl_pops", 32'(pops), 32'(vecs[v].exp_notes));
            check("tbl_pc", 32'(pc), 32'(vecs[v].exp_pc));
            check("tbl_bpm", 32'(bpm), 32'(vecs[v].exp_bpm));
        end

        // Reset while in WAIT with two notes queued.
        clear_sram();
        for (int i = 0; i < 8; i++) sram[i] = 16'h8100 + 16'(i);
        @(negedge CLK);
        start     = 1'b1;
        ins_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        repeat (8) @(negedge CLK);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_valid", 32'(ins_valid), 32'd1);
        RST = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_sram_a", 32'(SRAM_A), 32'd0);
        check("mid_rst_valid", 32'(ins_valid), 32'd0);
        check("mid_rst_data", 32'(ins_data), 32'd0);
        check("mid_rst_bpm", 32'(bpm), 32'd96);
        @(negedge CLK);
        RST = 1'b0;
        clear_sram();
        sram[0] = 16'h8123;
        sram[1] = 16'h8245;
        run_prog(0, -1);
        check("post_rst_pops", 32'(pops), 32'd2);

        // End of address space on the narrow instance.
        @(negedge CLK);
        w_start = 1'b1;
        @(negedge CLK);
        w_start = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            if (w_valid) begin
                check("wrap_data", 32'(w_data), 32'(16'h8000 + 16'(idx)));
                idx++;
            end
            if (w_done) break;
        end
        check("wrap_done", 32'(w_done), 32'd1);
        check("wrap_pops", 32'(idx), 32'd8);
        check("wrap_pc", 32'(w_pc), 32'd7);
        check("wrap_busy", 32'(w_busy), 32'd0);

        // Random programs with random handshake and occasional ignored restart.
        for (int t = 0; t < 20; t++) begin
            clear_sram();
            n = $urandom_range(1, 30);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 4 || r >= 8) begin
                    sram[i] = 16'h8000 | 16'($urandom_range(0, 32767));
                end else if (r <= 6) begin
                    sram[i] = ($urandom_range(0, 3) == 0) ? 16'h1000
                                                           : (16'h1000 | 16'($urandom_range(0, 4095)));
                end else begin
                    sram[i] = (16'($urandom_range(2, 7)) << 12) | 16'($urandom_range(0, 4095));
                end
            end
            rs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : -1;
            run_prog($urandom_range(0, 1), rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
